// File: rtl/led_sched_pkg.sv
// Shared definitions for the LED pattern scheduler: pattern codes, FSM states
// and the width of the millisecond counters.
package led_sched_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_ON   = 2'b01;
    localparam logic [1:0] MODE_SLOW = 2'b10;
    localparam logic [1:0] MODE_FAST = 2'b11;

    localparam int MS_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/led_pattern_sched_if.sv
// Request/grant/LED bundle of the LED pattern scheduler, plus FSM state debug view.
interface led_pattern_sched_if #(
    parameter int P_REQ_NUM    = 4,
    parameter int P_LED_NUMBER = 4
);
    import led_sched_pkg::*;

    // Level handshake: a requester holds i_req high for as long as it wants the
    // LED bank; o_gnt (registered, one-hot or zero) names the current owner, and
    // ownership ends when the owner drops i_req or is preempted after its hold.
    logic [P_REQ_NUM-1:0]    i_req;
    logic [2*P_REQ_NUM-1:0]  i_mode;
    logic [P_REQ_NUM-1:0]    o_gnt;
    logic                    o_busy;
    logic [P_LED_NUMBER-1:0] o_led;
    state_t                  o_state;

    modport master (output i_req, i_mode, input o_gnt, o_busy, o_led, o_state);
    modport slave  (input i_req, i_mode, output o_gnt, o_busy, o_led, o_state);

endinterface

// File: rtl/led_ms_tick.sv
// Millisecond prescaler: one-cycle pulse every P_TICK_DIV clocks, restartable.
module led_ms_tick #(
    parameter int unsigned P_TICK_DIV = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam logic [31:0] L_LAST = 32'(P_TICK_DIV - 1);

    logic [31:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_restart || r_cnt == L_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    assign o_tick = (r_cnt == L_LAST);

endmodule

// File: rtl/led_pattern_sched.sv
// Shares one LED bank between requesters; the owner's latched pattern is shown.
// Define LED_SCHED_RR_EN for round-robin arbitration, otherwise lowest index wins.
module led_pattern_sched
    import led_sched_pkg::*;
#(
    parameter int          P_LED_NUMBER = 4,
    parameter int          P_REQ_NUM    = 4,
    parameter int unsigned P_TICK_DIV   = 50000,
    parameter int          P_HOLD_MS    = 500,
    parameter int          P_SLOW_MS    = 500,
    parameter int          P_FAST_MS    = 100,
    parameter bit          P_LED_ON     = 1'b1
) (
    input logic                i_clk,
    input logic                i_rst,
    led_pattern_sched_if.slave bus
);

    localparam int IDXW = $clog2(P_REQ_NUM);
    localparam logic [MS_W-1:0] L_HOLD    = MS_W'(P_HOLD_MS);
    localparam logic [MS_W-1:0] L_SLOW_M1 = MS_W'(P_SLOW_MS - 1);
    localparam logic [MS_W-1:0] L_FAST_M1 = MS_W'(P_FAST_MS - 1);
    localparam logic [P_LED_NUMBER-1:0] L_LIT  = {P_LED_NUMBER{P_LED_ON}};
    localparam logic [P_LED_NUMBER-1:0] L_DARK = {P_LED_NUMBER{~P_LED_ON}};

    state_t                  r_state, w_next;
    logic [P_REQ_NUM-1:0]    r_gnt;
    logic [IDXW-1:0]         r_own, w_win;
    logic [1:0]              r_mode, w_new_mode;
    logic [MS_W-1:0]         r_hold, r_blink, w_half_m1;
    logic [P_LED_NUMBER-1:0] r_led;
    logic r_lit, w_lit_nxt, w_any, w_grant, w_tick, w_restart;
    logic w_hold_done, w_toggle, w_blink, w_other;

`ifdef LED_SCHED_RR_EN
    logic [IDXW-1:0] r_ptr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= (w_win == IDXW'(P_REQ_NUM - 1)) ? '0 : w_win + 1'b1;
        end
    end
`endif

    // Scan in search order from the top so the first requester found last wins.
    always_comb begin : p_arb
        int idx;
        int start;
        idx   = 0;
        w_win = '0;
`ifdef LED_SCHED_RR_EN
        start = int'(r_ptr);
`else
        start = 0;
`endif
        for (int i = P_REQ_NUM - 1; i >= 0; i--) begin
            idx = (start + i) % P_REQ_NUM;
            if (bus.i_req[idx]) w_win = IDXW'(idx);
        end
    end

    assign w_any      = |bus.i_req;
    assign w_other    = |(bus.i_req & ~r_gnt);
    assign w_new_mode = bus.i_mode[{w_win, 1'b0} +: 2];
    assign w_blink    = (r_mode == MODE_SLOW) || (r_mode == MODE_FAST);
    assign w_half_m1  = (r_mode == MODE_FAST) ? L_FAST_M1 : L_SLOW_M1;
    assign w_toggle   = w_tick && w_blink && (r_blink == w_half_m1);
    // The tick that completes the hold already counts, so expiry is seen on that cycle.
    assign w_hold_done = (r_hold == L_HOLD) || (w_tick && r_hold == L_HOLD - 1'b1);
    assign w_restart   = (w_next == ST_SHOW) && (r_state != ST_SHOW);

    led_ms_tick #(.P_TICK_DIV(P_TICK_DIV)) u_tick (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_restart(w_restart),
        .o_tick   (w_tick)
    );

    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_lit_nxt = 1'b0;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                w_next = ST_IDLE;
                if (w_any) begin
                    w_next    = ST_SHOW;
                    w_grant   = 1'b1;
                    w_lit_nxt = (w_new_mode == MODE_ON) || (w_new_mode == MODE_SLOW) ||
                                (w_new_mode == MODE_FAST);
                end
            end
            ST_SHOW: begin
                if (!bus.i_req[r_own] || (w_hold_done && w_other)) begin
                    w_next = ST_GAP;
                end else begin
                    w_lit_nxt = r_lit ^ w_toggle;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_own   <= '0;
            r_mode  <= MODE_OFF;
            r_hold  <= '0;
            r_blink <= '0;
            r_lit   <= 1'b0;
            r_led   <= L_DARK;
        end else begin
            r_state <= w_next;
            r_lit   <= w_lit_nxt;
            r_led   <= w_lit_nxt ? L_LIT : L_DARK;
            if (w_grant) begin
                r_gnt   <= {{(P_REQ_NUM-1){1'b0}}, 1'b1} << w_win;
                r_own   <= w_win;
                r_mode  <= w_new_mode;
                r_hold  <= '0;
                r_blink <= '0;
            end else if (w_next == ST_SHOW) begin
                if (w_tick && r_hold != L_HOLD) r_hold <= r_hold + 1'b1;
                if (w_tick && w_blink) r_blink <= w_toggle ? '0 : r_blink + 1'b1;
            end else begin
                r_gnt   <= '0;
                r_hold  <= '0;
                r_blink <= '0;
            end
        end
    end

    assign bus.o_gnt   = r_gnt;
    assign bus.o_busy  = (r_state == ST_SHOW);
    assign bus.o_led   = r_led;
    assign bus.o_state = r_state;

endmodule

// File: tb/tb_led_pattern_sched.sv
// Bench for led_pattern_sched: directed vector table, reset/arbitration sequences,
// and random traffic against a millisecond-level reference model.
module tb_led_pattern_sched;
    import led_sched_pkg::*;

    localparam int N = 4, LEDS = 4, DIV = 4, HOLD = 3, SLOW = 2, FAST = 1;

    logic clk = 1'b0;
    logic rst;

    led_pattern_sched_if #(.P_REQ_NUM(N), .P_LED_NUMBER(LEDS)) bus ();

    led_pattern_sched #(
        .P_LED_NUMBER(LEDS), .P_REQ_NUM(N), .P_TICK_DIV(DIV), .P_HOLD_MS(HOLD),
        .P_SLOW_MS(SLOW), .P_FAST_MS(FAST), .P_LED_ON(1'b1)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, sample at the next fall.
    task automatic step(input logic [3:0] req, input logic [7:0] mode);
        bus.i_req  = req;
        bus.i_mode = mode;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.i_req  = '0;
        bus.i_mode = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model: ownership tracked in elapsed clocks since grant.
    bit         m_show;
    int         m_own, m_el, m_ptr;
    logic [1:0] m_mode;

    task automatic model_reset();
        m_show = 0; m_own = 0; m_el = 0; m_ptr = 0; m_mode = 2'b00;
    endtask

    function automatic int pick(input logic [3:0] req);
        int start;
        start = 0;
`ifdef LED_SCHED_RR_EN
        start = m_ptr;
`endif
        for (int i = 0; i < N; i++) if (req[(start + i) % N]) return (start + i) % N;
        return 0;
    endfunction

    task automatic model_edge(input logic [3:0] req, input logic [7:0] mode);
        logic [3:0] others;
        if (m_show) begin
            m_el++;
            others = req;
            others[m_own] = 1'b0;
            if (!req[m_own]) m_show = 0;
            else if (m_el >= HOLD * DIV && others != 4'b0) m_show = 0;
        end else if (req != 4'b0) begin
            m_own  = pick(req);
            m_mode = mode[2*m_own +: 2];
            m_el   = 0;
            m_show = 1;
            m_ptr  = (m_own + 1) % N;
        end
    endtask

    function automatic logic [3:0] model_gnt();
        return m_show ? (4'b0001 << m_own) : 4'b0000;
    endfunction

    function automatic logic [3:0] model_led();
        int half;
        if (!m_show || m_mode == 2'b00) return 4'h0;
        if (m_mode == 2'b01) return 4'hF;
        half = (m_mode == 2'b10) ? SLOW : FAST;
        return ((m_el / (half * DIV)) % 2 == 0) ? 4'hF : 4'h0;
    endfunction

    typedef struct {
        logic [3:0] req;
        logic [7:0] mode;
        int         n;
        logic [3:0] gnt;
        logic       busy;
        logic [3:0] led;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic [3:0] req, input logic [7:0] mode, input int n,
                       input logic [3:0] gnt, input logic busy, input logic [3:0] led);
        vec_t v;
        v.req = req; v.mode = mode; v.n = n; v.gnt = gnt; v.busy = busy; v.led = led;
        vt.push_back(v);
    endtask

    logic [3:0] exp_q[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] prev, got, e, req;
        logic [7:0] mode;

        // Slow blink, mode change ignored, hold expiry without rivals, drop.
        add(4'b0001, 8'h02, 1, 4'b0001, 1'b1, 4'hF);
        add(4'b0001, 8'h00, 7, 4'b0001, 1'b1, 4'hF);
        add(4'b0001, 8'h00, 8, 4'b0001, 1'b1, 4'h0);
        add(4'b0001, 8'h00, 8, 4'b0001, 1'b1, 4'hF);
        add(4'b0000, 8'h00, 1, 4'b0000, 1'b0, 4'h0);
        add(4'b0000, 8'h00, 2, 4'b0000, 1'b0, 4'h0);
        // Preemption by requester 2 after the 12-cycle hold.
        add(4'b0001, 8'h55, 1, 4'b0001, 1'b1, 4'hF);
        add(4'b0101, 8'h55, 11, 4'b0001, 1'b1, 4'hF);
        add(4'b0101, 8'h55, 1, 4'b0000, 1'b0, 4'h0);
        add(4'b0100, 8'h55, 1, 4'b0100, 1'b1, 4'hF);
        add(4'b0000, 8'h55, 2, 4'b0000, 1'b0, 4'h0);
        // Owner drop during hold.
        add(4'b0001, 8'h55, 2, 4'b0001, 1'b1, 4'hF);
        add(4'b0000, 8'h55, 2, 4'b0000, 1'b0, 4'h0);
        // Fast blink.
        add(4'b0001, 8'h03, 4, 4'b0001, 1'b1, 4'hF);
        add(4'b0001, 8'h03, 4, 4'b0001, 1'b1, 4'h0);
        add(4'b0001, 8'h03, 4, 4'b0001, 1'b1, 4'hF);
        add(4'b0000, 8'h03, 2, 4'b0000, 1'b0, 4'h0);
        // Granted in mode off: busy with dark LEDs.
        add(4'b1000, 8'h00, 3, 4'b1000, 1'b1, 4'h0);
        add(4'b0000, 8'h00, 2, 4'b0000, 1'b0, 4'h0);

        rst = 1'b0;
        #1;
        do_reset();
        chk("reset gnt", 32'(bus.o_gnt), 32'h0);
        chk("reset busy", 32'(bus.o_busy), 32'h0);
        chk("reset led", 32'(bus.o_led), 32'h0);
        chk("reset state", 32'(bus.o_state), 32'(ST_IDLE));

        foreach (vt[k]) begin
            for (int c = 0; c < vt[k].n; c++) begin
                step(vt[k].req, vt[k].mode);
                chk($sformatf("vec%0d.%0d gnt", k, c), 32'(bus.o_gnt), 32'(vt[k].gnt));
                chk($sformatf("vec%0d.%0d busy", k, c), 32'(bus.o_busy), 32'(vt[k].busy));
                chk($sformatf("vec%0d.%0d led", k, c), 32'(bus.o_led), 32'(vt[k].led));
            end
        end

        // Asynchronous reset while requester 2 owns the bank.
        step(4'b0100, 8'h55);
        step(4'b0100, 8'h55);
        chk("pre_rst gnt", 32'(bus.o_gnt), 32'h4);
        #2 rst = 1'b1;
        #1;
        chk("async_rst gnt", 32'(bus.o_gnt), 32'h0);
        chk("async_rst busy", 32'(bus.o_busy), 32'h0);
        chk("async_rst led", 32'(bus.o_led), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Grant order with every requester asserted continuously.
`ifdef LED_SCHED_RR_EN
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        exp_q = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        prev = 4'b0;
        for (int c = 0; c < 120 && exp_q.size() > 0; c++) begin
            step(4'b1111, 8'h55);
            if (bus.o_gnt != 4'b0 && prev == 4'b0) begin
                got = bus.o_gnt;
                e = exp_q.pop_front();
                chk("grant_order", 32'(got), 32'(e));
            end
            prev = bus.o_gnt;
        end
        if (exp_q.size() != 0) chk("grant_order timeout", 32'(exp_q.size()), 32'h0);

        // Random traffic against the model.
        do_reset();
        model_reset();
        req = 4'b0;
        mode = 8'h0;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) mode = 8'($urandom_range(0, 255));
            step(req, mode);
            model_edge(req, mode);
            chk($sformatf("rnd%0d gnt", c), 32'(bus.o_gnt), 32'(model_gnt()));
            chk($sformatf("rnd%0d busy", c), 32'(bus.o_busy), 32'(m_show));
            chk($sformatf("rnd%0d led", c), 32'(bus.o_led), 32'(model_led()));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
